// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_if : VGA raster bundle shared by the timing, draw and overlay stages.
//
// Fields
//   hcount [10:0]  horizontal pixel counter
//   vcount [10:0]  vertical line counter
//   hsync          horizontal sync, active-high
//   hblnk          horizontal blanking
//   vsync          vertical sync, active-high
//   vblnk          vertical blanking
//   rgb    [11:0]  pixel colour, 4 bits per channel
//
// Modports
//   source : the stage that drives the bundle
//   sink   : a stage that consumes the bundle
// -----------------------------------------------------------------------------
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        hblnk;
   logic        vsync;
   logic        vblnk;
   logic [11:0] rgb;

   modport source (
      output hcount,
      output vcount,
      output hsync,
      output hblnk,
      output vsync,
      output vblnk,
      output rgb
   );

   modport sink (
      input hcount,
      input vcount,
      input hsync,
      input hblnk,
      input vsync,
      input vblnk,
      input rgb
   );
endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_pkg    : 1024x768 @ 60 Hz raster constants (65 MHz pixel clock).
// vga_timing : free-running raster timing generator.
//
// Ports
//   clk  in   pixel clock
//   rst  in   asynchronous, active-high reset
//   out  out  vga_if.source bundle: hcount, vcount, hsync, hblnk,
//             vsync, vblnk, rgb (rgb held at 12'h000)
//
// Counts and strobes are all registered together from the same next-state
// values, so the flags presented in any cycle always describe the counts
// presented in that same cycle.
//
// Optional build macro
//   VGA_TIMING_SVA_EN : compiles embedded concurrent assertions (ranges,
//                       window equations, counter stepping). No effect on
//                       the synthesised logic.
// -----------------------------------------------------------------------------
package vga_pkg;
   localparam logic [10:0] H_COUNT_TOT  = 11'd1343;
   localparam logic [10:0] H_BLNK_START = 11'd1024;
   localparam logic [10:0] H_BLNK_END   = 11'd1344;
   localparam logic [10:0] H_SYNC_START = 11'd1048;
   localparam logic [10:0] H_SYNC_END   = 11'd1184;

   localparam logic [10:0] V_COUNT_TOT  = 11'd805;
   localparam logic [10:0] V_BLNK_START = 11'd768;
   localparam logic [10:0] V_BLNK_END   = 11'd806;
   localparam logic [10:0] V_SYNC_START = 11'd771;
   localparam logic [10:0] V_SYNC_END   = 11'd777;
endpackage

module vga_timing
   import vga_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   vga_if.source  out
);

   logic [10:0] hcount_q;
   logic [10:0] vcount_q;
   logic        hsync_q;
   logic        hblnk_q;
   logic        vsync_q;
   logic        vblnk_q;

   logic [10:0] hcount_nxt;
   logic [10:0] vcount_nxt;
   logic        hsync_nxt;
   logic        hblnk_nxt;
   logic        vsync_nxt;
   logic        vblnk_nxt;
   logic        h_wrap;
   logic        v_wrap;

   // >= rather than == so an out-of-range count (e.g. after an upset)
   // falls back into the legal range at the next line boundary.
   assign h_wrap = (hcount_q >= H_COUNT_TOT);
   assign v_wrap = (vcount_q >= V_COUNT_TOT);

   assign hcount_nxt = h_wrap ? 11'd0 : hcount_q + 11'd1;
   assign vcount_nxt = !h_wrap ? vcount_q :
                       (v_wrap ? 11'd0 : vcount_q + 11'd1);

   // Strobes are decoded from the next counts, not the current ones, so
   // that they land in the flops on the same edge as the counts they
   // describe. The vertical strobes therefore only move at the h wrap.
   assign hblnk_nxt = (hcount_nxt >= H_BLNK_START) && (hcount_nxt < H_BLNK_END);
   assign hsync_nxt = (hcount_nxt >= H_SYNC_START) && (hcount_nxt < H_SYNC_END);
   assign vblnk_nxt = (vcount_nxt >= V_BLNK_START) && (vcount_nxt < V_BLNK_END);
   assign vsync_nxt = (vcount_nxt >= V_SYNC_START) && (vcount_nxt < V_SYNC_END);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_q <= 11'd0;
         vcount_q <= 11'd0;
         hsync_q  <= 1'b0;
         hblnk_q  <= 1'b0;
         vsync_q  <= 1'b0;
         vblnk_q  <= 1'b0;
      end else begin
         hcount_q <= hcount_nxt;
         vcount_q <= vcount_nxt;
         hsync_q  <= hsync_nxt;
         hblnk_q  <= hblnk_nxt;
         vsync_q  <= vsync_nxt;
         vblnk_q  <= vblnk_nxt;
      end
   end

   assign out.hcount = hcount_q;
   assign out.vcount = vcount_q;
   assign out.hsync  = hsync_q;
   assign out.hblnk  = hblnk_q;
   assign out.vsync  = vsync_q;
   assign out.vblnk  = vblnk_q;
   assign out.rgb    = 12'h000;

`ifdef VGA_TIMING_SVA_EN
   a_hcount_range: assert property (@(posedge clk) disable iff (rst)
      hcount_q <= H_COUNT_TOT)
      else $error("vga_timing: hcount out of range (%0d)", hcount_q);

   a_vcount_range: assert property (@(posedge clk) disable iff (rst)
      vcount_q <= V_COUNT_TOT)
      else $error("vga_timing: vcount out of range (%0d)", vcount_q);

   a_hblnk_window: assert property (@(posedge clk) disable iff (rst)
      hblnk_q == ((hcount_q >= H_BLNK_START) && (hcount_q < H_BLNK_END)))
      else $error("vga_timing: hblnk=%0b at hcount %0d", hblnk_q, hcount_q);

   a_hsync_window: assert property (@(posedge clk) disable iff (rst)
      hsync_q == ((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END)))
      else $error("vga_timing: hsync=%0b at hcount %0d", hsync_q, hcount_q);

   a_vblnk_window: assert property (@(posedge clk) disable iff (rst)
      vblnk_q == ((vcount_q >= V_BLNK_START) && (vcount_q < V_BLNK_END)))
      else $error("vga_timing: vblnk=%0b at vcount %0d", vblnk_q, vcount_q);

   a_vsync_window: assert property (@(posedge clk) disable iff (rst)
      vsync_q == ((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END)))
      else $error("vga_timing: vsync=%0b at vcount %0d", vsync_q, vcount_q);

   a_hcount_step: assert property (@(posedge clk) disable iff (rst)
      hcount_q == (($past(hcount_q) == H_COUNT_TOT) ? 11'd0
                                                    : $past(hcount_q) + 11'd1))
      else $error("vga_timing: hcount stepped %0d -> %0d",
                  $past(hcount_q), hcount_q);

   a_vcount_hold: assert property (@(posedge clk) disable iff (rst)
      ($past(hcount_q) != H_COUNT_TOT) |-> (vcount_q == $past(vcount_q)))
      else $error("vga_timing: vcount moved without an hcount wrap");

   a_vcount_step: assert property (@(posedge clk) disable iff (rst)
      ($past(hcount_q) == H_COUNT_TOT) |->
         (vcount_q == (($past(vcount_q) == V_COUNT_TOT) ? 11'd0
                                                        : $past(vcount_q) + 11'd1)))
      else $error("vga_timing: vcount stepped %0d -> %0d",
                  $past(vcount_q), vcount_q);
`endif

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

   logic clk;
   logic rst;

   vga_if vif ();

   vga_timing dut (
      .clk (clk),
      .rst (rst),
      .out (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference raster position of the bundle currently on the outputs
   int mh;
   int mv;

   logic [10:0] pl_h;
   logic [10:0] pl_v;

   int cnt;
   int first_hs;
   int last_hs;
   int first_hb;
   int n;

   // ---- reference model: plain arithmetic on the raster rules ----
   function automatic logic exp_hblnk(int h); return (h >= 1024);               endfunction
   function automatic logic exp_hsync(int h); return (h >= 1048 && h < 1184);  endfunction
   function automatic logic exp_vblnk(int v); return (v >= 768);                endfunction
   function automatic logic exp_vsync(int v); return (v >= 771 && v < 777);    endfunction

   task automatic model_step();
      if (mh == 1343) begin
         mh = 0;
         mv = (mv == 805) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".hcount"}, 32'(vif.hcount), 32'(mh));
      chk({tag, ".vcount"}, 32'(vif.vcount), 32'(mv));
      chk({tag, ".hsync"},  32'(vif.hsync),  32'(exp_hsync(mh)));
      chk({tag, ".hblnk"},  32'(vif.hblnk),  32'(exp_hblnk(mh)));
      chk({tag, ".vsync"},  32'(vif.vsync),  32'(exp_vsync(mv)));
      chk({tag, ".vblnk"},  32'(vif.vblnk),  32'(exp_vblnk(mv)));
      chk({tag, ".rgb"},    32'(vif.rgb),    32'd0);
      checks++;
      assert (vif.hcount <= 11'd1343 && vif.vcount <= 11'd805)
      else begin
         errors++;
         $error("FAIL %s.range observed h=%0d v=%0d expected h<=1343 v<=805",
                tag, vif.hcount, vif.vcount);
      end
   endtask

   // one clock edge, model follows, sample 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic run(string tag, int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         check_all(tag);
      end
   endtask

   // Jump the raster to (h,v) by overriding the next-count nets for one edge.
   task preload(int h, int v);
      pl_h = 11'(h);
      pl_v = 11'(v);
      @(negedge clk);
      force dut.hcount_nxt = pl_h;
      force dut.vcount_nxt = pl_v;
      @(posedge clk);
      #1;
      release dut.hcount_nxt;
      release dut.vcount_nxt;
      mh = h;
      mv = v;
   endtask

   initial begin
      mh = 0;
      mv = 0;
      rst = 1'b1;
      #1;
      check_all("reset_async");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("reset_held");

      // release: first edge gives hcount 1
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("first_edge.hcount", 32'(vif.hcount), 32'd1);
      chk("first_edge.vcount", 32'(vif.vcount), 32'd0);

      // rest of line 0: horizontal strobe placement and width
      cnt = 0; first_hs = -1; last_hs = -1; first_hb = -1;
      for (int i = 0; i < 1342; i++) begin
         tick();
         check_all("line0");
         if (vif.hsync === 1'b1) begin
            cnt++;
            if (first_hs < 0) first_hs = int'(vif.hcount);
            last_hs = int'(vif.hcount);
         end
         if (vif.hblnk === 1'b1 && first_hb < 0) first_hb = int'(vif.hcount);
      end
      chk("hsync_width", 32'(cnt),      32'd136);
      chk("hsync_first", 32'(first_hs), 32'd1048);
      chk("hsync_last",  32'(last_hs),  32'd1183);
      chk("hblnk_rise",  32'(first_hb), 32'd1024);

      // natural counting to (1343,5), then the line wrap
      run("lines", 5 * 1344);
      chk("pre_wrap.hcount", 32'(vif.hcount), 32'd1343);
      chk("pre_wrap.vcount", 32'(vif.vcount), 32'd5);
      tick();
      check_all("line_wrap");
      chk("line_wrap.hcount", 32'(vif.hcount), 32'd0);
      chk("line_wrap.vcount", 32'(vif.vcount), 32'd6);

      // vblnk rising boundary
      preload(1342, 767);
      check_all("vblnk_pre");
      tick();
      chk("vblnk_767", 32'(vif.vblnk), 32'd0);
      tick();
      check_all("vblnk_rise");
      chk("vblnk_768", 32'(vif.vblnk), 32'd1);

      // vsync pulse: rise at 771, held for whole lines, fall at 777
      preload(1343, 770);
      chk("vsync_770", 32'(vif.vsync), 32'd0);
      tick();
      check_all("vsync_rise");
      chk("vsync_771", 32'(vif.vsync), 32'd1);
      cnt = 1;
      for (int i = 0; i < 9000; i++) begin
         tick();
         check_all("vsync_pulse");
         if (vif.vsync !== 1'b1) break;
         cnt++;
      end
      chk("vsync_width", 32'(cnt), 32'd8064);
      chk("vsync_fall.vcount", 32'(vif.vcount), 32'd777);
      chk("vsync_fall.hcount", 32'(vif.hcount), 32'd0);

      // simultaneous wrap at end of frame, then one full line period
      preload(1343, 805);
      chk("frame_end.vblnk", 32'(vif.vblnk), 32'd1);
      tick();
      check_all("frame_wrap");
      chk("frame_wrap.hcount", 32'(vif.hcount), 32'd0);
      chk("frame_wrap.vcount", 32'(vif.vcount), 32'd0);
      chk("frame_wrap.vblnk",  32'(vif.vblnk),  32'd0);
      run("line_period", 1344);
      chk("line_period.hcount", 32'(vif.hcount), 32'd0);
      chk("line_period.vcount", 32'(vif.vcount), 32'd1);

      // random raster positions
      for (int k = 0; k < 5; k++) begin
         preload(int'($urandom_range(0, 1343)), int'($urandom_range(0, 805)));
         n = int'($urandom_range(20, 400));
         run("random", n);
      end

      // mid-frame reset: outputs clear with no clock edge
      preload(int'($urandom_range(695, 705)), int'($urandom_range(395, 405)));
      run("pre_reset", int'($urandom_range(1, 8)));
      @(negedge clk);
      #1;
      rst = 1'b1;
      mh = 0;
      mv = 0;
      #1;
      check_all("mid_reset_async");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("mid_reset_held");
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("restart.hcount", 32'(vif.hcount), 32'd1);
      chk("restart.vcount", 32'(vif.vcount), 32'd0);
      run("restart", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
